// File: rtl/if_id_stall_reg_if.sv
// Handshake and data bundle between the fetch stage, hazard unit and the IF/ID stall register.
// master drives the control/fetch inputs; slave is the pipeline register itself.
interface if_id_stall_reg_if;
  logic        start_i;
  logic        pc_hold_i;
  logic        ifid_hold_i;
  logic        flush_i;
  logic [31:0] pc_next_i;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;
  logic [15:0] stall_cnt_o;
  logic        running_o;

  modport master (
    output start_i, pc_hold_i, ifid_hold_i, flush_i, pc_next_i, inst_i,
    input  pc_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, stall_cnt_o, running_o
  );

  modport slave (
    input  start_i, pc_hold_i, ifid_hold_i, flush_i, pc_next_i, inst_i,
    output pc_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, stall_cnt_o, running_o
  );
endinterface

// File: rtl/if_id_stall_reg.sv
// Fetch PC register plus IF/ID pipeline register with independent PC/IF-ID holds,
// branch flush and a saturating stall-cycle counter.
module if_id_stall_reg (
  input  logic             clk_i,
  input  logic             rst_i,
  if_id_stall_reg_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_inst_r;
  logic        ifid_valid_r;
  logic [15:0] stall_cnt_r;

  // Link address of the fetched instruction; wraps modulo 2^32 by design.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Saturating increment so a long stall never wraps the counter back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

  // Sequencer, PC register, IF/ID register and stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      pc_r         <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_inst_r  <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      stall_cnt_r  <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          // Bubble the IF/ID stage while waiting; PC stays at the reset vector.
          ifid_pc_r    <= 32'h0000_0000;
          ifid_inst_r  <= 32'h0000_0000;
          ifid_valid_r <= 1'b0;
          if (bus.start_i) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Flush overrides both holds: the redirect target must be taken now.
          if (bus.flush_i) begin
            pc_r <= bus.pc_next_i;
          end else if (bus.pc_hold_i) begin
            pc_r <= pc_r;
          end else begin
            pc_r <= bus.pc_next_i;
          end

          if (bus.flush_i) begin
            ifid_inst_r  <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            ifid_pc_r    <= pc_plus4(pc_r);
          end else if (bus.ifid_hold_i) begin
            ifid_inst_r  <= ifid_inst_r;
            ifid_valid_r <= ifid_valid_r;
            ifid_pc_r    <= ifid_pc_r;
          end else begin
            ifid_inst_r  <= bus.inst_i;
            ifid_valid_r <= 1'b1;
            ifid_pc_r    <= pc_plus4(pc_r);
          end

          if (bus.ifid_hold_i && !bus.flush_i) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
          end else begin
            stall_cnt_r <= stall_cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc_o         = pc_r;
  assign bus.ifid_pc_o    = ifid_pc_r;
  assign bus.ifid_inst_o  = ifid_inst_r;
  assign bus.ifid_valid_o = ifid_valid_r;
  assign bus.stall_cnt_o  = stall_cnt_r;
  assign bus.running_o    = (state_r == RUN);

endmodule

// File: tb/tb_if_id_stall_reg.sv
// Bench for if_id_stall_reg: directed scenarios plus randomized traffic checked
// against a pipeline reference model.
module tb_if_id_stall_reg;

  logic clk_i;
  logic rst_i;
  if_id_stall_reg_if bus ();

  if_id_stall_reg dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction memory: content is a function of address.
  assign bus.inst_i = 32'h1111_0000 + bus.pc_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_inst;
  bit          m_valid;
  int          m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string where);
    chk({where, ".pc"},        bus.pc_o, m_pc);
    chk({where, ".ifid_pc"},   bus.ifid_pc_o, m_ifid_pc);
    chk({where, ".ifid_inst"}, bus.ifid_inst_o, m_ifid_inst);
    chk({where, ".valid"},     {31'd0, bus.ifid_valid_o}, {31'd0, m_valid});
    chk({where, ".stall_cnt"}, {16'd0, bus.stall_cnt_o}, m_cnt[31:0]);
    chk({where, ".running"},   {31'd0, bus.running_o}, {31'd0, m_run});
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pc = 32'd0; m_ifid_pc = 32'd0; m_ifid_inst = 32'd0;
    m_valid = 1'b0; m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] old_pc;
    if (!m_run) begin
      m_run       = bus.start_i;
      m_ifid_pc   = 32'd0;
      m_ifid_inst = 32'd0;
      m_valid     = 1'b0;
    end else begin
      old_pc = m_pc;
      if (bus.flush_i || !bus.pc_hold_i) m_pc = bus.pc_next_i;
      if (bus.flush_i) begin
        m_ifid_inst = 32'd0; m_valid = 1'b0; m_ifid_pc = old_pc + 32'd4;
      end else if (!bus.ifid_hold_i) begin
        m_ifid_inst = mem_word(old_pc); m_valid = 1'b1; m_ifid_pc = old_pc + 32'd4;
      end
      if (bus.ifid_hold_i && !bus.flush_i && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic step(input bit do_check, input string where);
    model_edge();
    @(posedge clk_i);
    #1;
    if (do_check) chk_all(where);
  endtask

  task automatic drive(input bit st, input bit ph, input bit ih, input bit fl, input logic [31:0] nxt);
    bus.start_i = st; bus.pc_hold_i = ph; bus.ifid_hold_i = ih; bus.flush_i = fl; bus.pc_next_i = nxt;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    model_reset();
    chk_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    #12;
    chk_all("por");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Idle ignores holds/flush and keeps the pipeline empty.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
    step(1'b1, "idle_ign");

    // Start, then three free-running fetches.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h99);
    step(1'b1, "start");
    chk("start.pc_not_loaded", bus.pc_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      step(1'b1, "run3");
    end
    chk("seq.pc", bus.pc_o, 32'd12);
    chk("seq.ifid_pc", bus.ifid_pc_o, 32'd12);
    chk("seq.ifid_inst", bus.ifid_inst_o, 32'h1111_0008);
    chk("seq.valid", {31'd0, bus.ifid_valid_o}, 32'd1);

    // Two-cycle combined hold at pc 8.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, "start2");
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      step(1'b1, "pre_hold");
    end
    chk("hold.pc_start", bus.pc_o, 32'd8);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, m_pc + 32'd4);
      step(1'b1, "hold");
    end
    chk("hold.pc", bus.pc_o, 32'd8);
    chk("hold.ifid_inst", bus.ifid_inst_o, 32'h1111_0004);
    chk("hold.cnt", {16'd0, bus.stall_cnt_o}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
    step(1'b1, "unhold");
    chk("unhold.pc", bus.pc_o, 32'd12);

    // Flush beats both holds.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, "flush");
    chk("flush.pc", bus.pc_o, 32'h40);
    chk("flush.inst", bus.ifid_inst_o, 32'd0);
    chk("flush.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    chk("flush.cnt", {16'd0, bus.stall_cnt_o}, 32'd2);

    // Start ignored in RUN; randomized traffic with independent holds.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] nxt;
      nxt = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), nxt);
      step(1'b1, "rand");
    end

    // Counter saturation.
    drive(1'b0, 1'b1, 1'b1, 1'b0, m_pc);
    for (int i = 0; i < 65535; i++) step(1'b0, "sat");
    chk_all("sat_reach");
    step(1'b1, "sat_hold");
    chk("sat.cnt", {16'd0, bus.stall_cnt_o}, 32'h0000_FFFF);

    // PC wraparound on the link address.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(1'b1, "wrap_load");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, "wrap");
    chk("wrap.ifid_pc", bus.ifid_pc_o, 32'd0);
    chk("wrap.ifid_inst", bus.ifid_inst_o, 32'h1110_FFFC);

    // Async reset mid-hold, start held through reset, then release between edges.
    drive(1'b0, 1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    step(1'b1, "pre_rst_hold");
    #2;
    rst_i = 1'b1;
    bus.start_i = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk_i);
    #1;
    chk_all("rst_edge");
    #1;
    rst_i = 1'b0;
    #1;
    chk_all("rst_release");
    step(1'b1, "restart");
    chk("restart.running", {31'd0, bus.running_o}, 32'd1);
    chk("restart.pc", bus.pc_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stall_reg.md
IF_ID_STALL_REG -- requirements
Module: if_id_stall_reg

Interface
REQ-001 SHALL have port: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst_i  input  1  asynchronous, active-high reset; acts immediately, independent of clk_i.
REQ-003 SHALL have port: start_i  input  1  begins fetch; sampled only in IDLE.
REQ-004 SHALL have port: pc_hold_i  input  1  PC hold request from hazard detection (load-use stall).
REQ-005 SHALL have port: ifid_hold_i  input  1  IF/ID hold request from hazard detection.
REQ-006 SHALL have port: flush_i  input  1  branch-taken flush from ID stage.
REQ-007 SHALL have port: pc_next_i  input  32  next-PC from upstream mux (PC+4 or branch/jump target).
REQ-008 SHALL have port: inst_i  input  32  instruction read combinationally at address pc_o.
REQ-009 SHALL have port: pc_o  output  32  current fetch PC (registered).
REQ-010 SHALL have port: ifid_pc_o  output  32  PC+4 of instruction held in IF/ID.
REQ-011 SHALL have port: ifid_inst_o  output  32  instruction held in IF/ID; 32'h0000_0000 is the NOP.
REQ-012 SHALL have port: ifid_valid_o  output  1  1 = IF/ID holds a real instruction.
REQ-013 SHALL have port: stall_cnt_o  output  16  count of stall cycles.
REQ-014 SHALL have port: running_o  output  1  1 when state is RUN.

Function
REQ-015 SHALL implement a two-state machine: IDLE, RUN; running_o = (state == RUN), combinational from state.
REQ-016 IDLE: pc_o holds; IF/ID loads NOP (inst 0, valid 0, ifid_pc 0); stall_cnt_o holds; pc_hold_i, ifid_hold_i, flush_i ignored.
REQ-017 IDLE -> RUN on a rising edge with start_i = 1; pc_o is not updated on that edge; first fetch address is the reset PC 0.
REQ-018 RUN SHALL be left only by rst_i; start_i ignored in RUN.
REQ-019 RUN, PC update priority: flush_i = 1 -> pc_o <= pc_next_i; else pc_hold_i = 1 -> pc_o holds; else pc_o <= pc_next_i.
REQ-020 RUN, IF/ID update priority: flush_i = 1 -> ifid_inst_o <= 0, ifid_valid_o <= 0, ifid_pc_o <= pc_o + 4; else ifid_hold_i = 1 -> all IF/ID outputs hold; else ifid_inst_o <= inst_i, ifid_pc_o <= pc_o + 4, ifid_valid_o <= 1.
REQ-021 pc_o + 4 SHALL be 32-bit modulo (32'hFFFF_FFFC + 4 = 0); no overflow flag.
REQ-022 pc_hold_i and ifid_hold_i SHALL be acted on independently; unequal values are legal (PC may advance while IF/ID holds and vice versa).
REQ-023 stall_cnt_o SHALL increment by 1 on each RUN edge with ifid_hold_i = 1 and flush_i = 0; saturates at 16'hFFFF.
REQ-024 Latency: instruction at pc_o appears on ifid_inst_o one edge later when not held or flushed.
REQ-025 Hold spanning N consecutive cycles SHALL keep IF/ID and PC stable for exactly N edges, resuming on the first edge with hold deasserted.

Reset
REQ-026 rst_i = 1 SHALL immediately force: state IDLE, pc_o 0, ifid_pc_o 0, ifid_inst_o 0, ifid_valid_o 0, stall_cnt_o 0, running_o 0.
REQ-027 Reset asserted mid-RUN, including during a hold or flush, SHALL discard in-flight state; after release the block waits in IDLE for start_i.
REQ-028 Reset release SHALL not itself cause any register update; first update on the next rising edge with rst_i = 0.

Verification
REQ-029 Reset, start_i pulse, pc_next_i = pc_o + 4, inst_i = 32'h1111_0000 + pc_o -> after 3 edges in RUN: pc_o = 12, ifid_pc_o = 12, ifid_inst_o = 32'h1111_0008, ifid_valid_o = 1.
REQ-030 In RUN at pc_o = 8, pc_hold_i = ifid_hold_i = 1 for 2 edges -> pc_o stays 8, IF/ID unchanged, stall_cnt_o 0 -> 2; next free edge pc_o = 12.
REQ-031 flush_i = 1 with pc_hold_i = ifid_hold_i = 1, pc_next_i = 32'h40 -> pc_o = 32'h40, ifid_inst_o = 0, ifid_valid_o = 0, stall_cnt_o unchanged.
REQ-032 Force stall_cnt_o to 16'hFFFF via 65535 hold cycles, one more hold -> stays 16'hFFFF; pc_o = 32'hFFFF_FFFC free-running -> ifid_pc_o = 0.
REQ-033 Assert rst_i asynchronously mid-hold between clock edges -> all outputs 0 before next edge; start_i held high during IDLE in RUN-less cycles, then after release, one edge -> running_o = 1, pc_o = 0.
